// File: rtl/fp_result_collector.sv
// Serial result collector for the FP adder: drives output_clk, samples serial_out MSB-first,
// and hands each assembled word to on-chip logic through a valid/ready holding register.
module fp_result_collector #(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             output_rdy_in,
  input  logic             serial_in,
  output logic             output_clk_out,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             abort_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] frame_cnt_out
);

  // state     | meaning
  // IDLE      | waiting for a result and a free holding register
  // LOW       | output_clk low phase; last cycle samples a bit and raises the strobe
  // HIGH      | output_clk high phase; last cycle lowers the strobe
  // DONE      | publish the assembled word
  // WAIT_DROP | frame complete, waiting for the adder to drop output_rdy
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW       = 3'd1,
    HIGH      = 3'd2,
    DONE      = 3'd3,
    WAIT_DROP = 3'd4
  } state_t;

  localparam int BIT_W = $clog2(WIDTH);
  localparam int PH_W  = $clog2(HALF_PERIOD);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);

  logic rst_meta_q, rst_n_q;
  logic rdy_meta_q, rdy_s_q;
  logic ser_meta_q, ser_s_q;

  state_t             state_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [PH_W-1:0]    phase_cnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   result_q;
  logic               valid_q;
  logic               oclk_q;
  logic               abort_q;
  logic               busy_q;
  logic [CNT_W-1:0]   frame_cnt_q;

  // Reset asserts immediately through the async clear; release is retimed to clk_in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_q) begin
    if (!rst_n_q) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      ser_meta_q <= 1'b0;
      ser_s_q    <= 1'b0;
    end else begin
      rdy_meta_q <= output_rdy_in;
      rdy_s_q    <= rdy_meta_q;
      ser_meta_q <= serial_in;
      ser_s_q    <= ser_meta_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      phase_cnt_q <= '0;
      shift_q     <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      oclk_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      abort_q <= 1'b0;
      if (valid_q && result_ready_in) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          oclk_q <= 1'b0;
          if (rdy_s_q && (!valid_q || result_ready_in)) begin
            state_q     <= LOW;
            bit_cnt_q   <= '0;
            phase_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end

        LOW: begin
          if (!rdy_s_q) begin
            state_q <= IDLE;
            oclk_q  <= 1'b0;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (phase_cnt_q == PH_LAST) begin
            shift_q     <= {shift_q[WIDTH-2:0], ser_s_q};
            oclk_q      <= 1'b1;
            phase_cnt_q <= '0;
            state_q     <= HIGH;
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end

        HIGH: begin
          if (!rdy_s_q) begin
            state_q <= IDLE;
            oclk_q  <= 1'b0;
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (phase_cnt_q == PH_LAST) begin
            oclk_q      <= 1'b0;
            phase_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= LOW;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q + 1'b1;
          end
        end

        // A coincident consumption is overridden here so the new word stays valid.
        DONE: begin
          result_q    <= shift_q;
          valid_q     <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 1'b1;
          busy_q      <= 1'b0;
          state_q     <= WAIT_DROP;
        end

        WAIT_DROP: begin
          if (!rdy_s_q) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          oclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign output_clk_out   = oclk_q;
  assign result_out       = result_q;
  assign result_valid_out = valid_q;
  assign abort_out        = abort_q;
  assign busy_out         = busy_q;
  assign frame_cnt_out    = frame_cnt_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector with a behavioural adder serialiser on output_clk.
module tb_fp_result_collector;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        output_rdy_in = 1'b0;
  logic        serial_in;
  logic        output_clk_out;
  logic [31:0] result_out;
  logic        result_valid_out;
  logic        result_ready_in = 1'b0;
  logic        abort_out;
  logic        busy_out;
  logic [7:0]  frame_cnt_out;

  int checks = 0;
  int errors = 0;

  int          edge_cnt = 0;
  int          tx_base = 0;
  logic [31:0] tx_word = '0;
  int          abort_cnt = 0;
  logic [7:0]  prev_cnt = '0;
  bit          wrap_seen = 1'b0;

  fp_result_collector #(.WIDTH(32), .HALF_PERIOD(4), .CNT_W(8)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .output_rdy_in    (output_rdy_in),
    .serial_in        (serial_in),
    .output_clk_out   (output_clk_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .abort_out        (abort_out),
    .busy_out         (busy_out),
    .frame_cnt_out    (frame_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // Adder model: bit k of the frame is presented after k output_clk rising edges.
  always @(posedge output_clk_out) edge_cnt = edge_cnt + 1;

  always_comb begin
    int idx;
    idx = edge_cnt - tx_base;
    serial_in = 1'b0;
    if (idx >= 0 && idx < 32) serial_in = tx_word[31 - idx];
  end

  always @(posedge clk_in) begin
    if (abort_out) abort_cnt = abort_cnt + 1;
    if (prev_cnt == 8'hFF && frame_cnt_out == 8'h00) wrap_seen = 1'b1;
    prev_cnt = frame_cnt_out;
  end

  task automatic run_frame(input logic [31:0] word, output bit ok);
    logic [7:0] start;
    int n;
    start   = frame_cnt_out;
    tx_word = word;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    n = 0;
    while (frame_cnt_out == start && n < 600) begin
      @(negedge clk_in);
      n++;
    end
    ok = (frame_cnt_out != start);
    output_rdy_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_reset();
    #3 rst_in = 1'b0;
    #1;
    checks++;
    if ({output_clk_out, result_valid_out, abort_out, busy_out} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {output_clk_out, result_valid_out, abort_out, busy_out});
    end
    checks++;
    if (result_out !== 32'h0 || frame_cnt_out !== 8'h0) begin
      errors++; $display("FAIL reset_data: got result %h cnt %0d expected 0 and 0", result_out, frame_cnt_out);
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0 || output_clk_out !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy %b oclk %b expected 0 0", busy_out, output_clk_out);
    end
  endtask

  task automatic test_basic_frame();
    int a0;
    a0 = abort_cnt;
    result_ready_in = 1'b0;
    tx_word = 32'h40490FDB;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 2) begin
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL busy_e2: got %b expected 0", busy_out); end
      end
      if (k == 3) begin
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_e3: got %b expected 1", busy_out); end
      end
      if (k == 6 || k == 11 || k == 19) begin
        checks++;
        if (output_clk_out !== 1'b0) begin errors++; $display("FAIL oclk_low_e%0d: got %b expected 0", k, output_clk_out); end
      end
      if (k == 7 || k == 15 || k == 255) begin
        checks++;
        if (output_clk_out !== 1'b1) begin errors++; $display("FAIL oclk_high_e%0d: got %b expected 1", k, output_clk_out); end
      end
      if (k == 259) begin
        checks++;
        if (result_valid_out !== 1'b0) begin errors++; $display("FAIL valid_e259: got %b expected 0", result_valid_out); end
      end
    end
    checks++;
    if (result_valid_out !== 1'b1) begin errors++; $display("FAIL valid_e260: got %b expected 1", result_valid_out); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL busy_e260: got %b expected 0", busy_out); end
    checks++;
    if (edge_cnt - tx_base != 32) begin errors++; $display("FAIL basic_edges: got %0d expected 32", edge_cnt - tx_base); end
    checks++;
    if (result_out !== 32'h40490FDB) begin errors++; $display("FAIL basic_result: got %h expected 40490fdb", result_out); end
    checks++;
    if (frame_cnt_out !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d expected 1", frame_cnt_out); end
    output_rdy_in = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++;
    if (abort_cnt != a0) begin errors++; $display("FAIL basic_abort: got %0d expected %0d", abort_cnt, a0); end
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0) begin errors++; $display("FAIL basic_consume: got %b expected 0", result_valid_out); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    result_ready_in = 1'b0;
    run_frame(32'h3F800000, ok);
    checks++;
    if (!ok || result_out !== 32'h3F800000) begin
      errors++; $display("FAIL bp_first: got %h ok %0d expected 3f800000 ok 1", result_out, ok);
    end
    tx_word = 32'hC0000000;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    repeat (50) @(negedge clk_in);
    checks++;
    if (edge_cnt != tx_base || busy_out !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got edges %0d busy %b expected 0 0", edge_cnt - tx_base, busy_out);
    end
    checks++;
    if (result_valid_out !== 1'b1 || result_out !== 32'h3F800000) begin
      errors++; $display("FAIL bp_hold: got %h valid %b expected 3f800000 1", result_out, result_valid_out);
    end
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    checks++;
    if (result_valid_out !== 1'b0 || busy_out !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid %b busy %b expected 0 1", result_valid_out, busy_out);
    end
    n = 0;
    while (frame_cnt_out != 8'd3 && n < 600) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (frame_cnt_out !== 8'd3 || result_out !== 32'hC0000000 || edge_cnt - tx_base != 32) begin
      errors++; $display("FAIL bp_second: got %h cnt %0d edges %0d expected c0000000 3 32", result_out, frame_cnt_out, edge_cnt - tx_base);
    end
    output_rdy_in = 1'b0;
    result_ready_in = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_abort();
    logic [31:0] r0;
    logic [7:0]  f0;
    int a0, n;
    r0 = result_out; f0 = frame_cnt_out; a0 = abort_cnt;
    tx_word = 32'h55AA33CC;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    n = 0;
    while (edge_cnt - tx_base < 10 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (edge_cnt - tx_base != 10) begin errors++; $display("FAIL abort_reach: got %0d edges expected 10", edge_cnt - tx_base); end
    output_rdy_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 2) begin
        checks++;
        if (abort_out !== 1'b0) begin errors++; $display("FAIL abort_early: got %b expected 0", abort_out); end
      end
    end
    checks++;
    if (output_clk_out !== 1'b0 || abort_out !== 1'b1 || busy_out !== 1'b0) begin
      errors++; $display("FAIL abort_now: got oclk %b abort %b busy %b expected 0 1 0", output_clk_out, abort_out, busy_out);
    end
    repeat (4) @(negedge clk_in);
    checks++;
    if (abort_cnt != a0 + 1) begin errors++; $display("FAIL abort_pulses: got %0d expected %0d", abort_cnt - a0, 1); end
    checks++;
    if (result_out !== r0 || frame_cnt_out !== f0 || edge_cnt - tx_base != 10) begin
      errors++; $display("FAIL abort_keep: got %h cnt %0d edges %0d expected %h %0d 10", result_out, frame_cnt_out, edge_cnt - tx_base, r0, f0);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int a0, n;
    a0 = abort_cnt;
    tx_word = 32'hFFFF0000;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    n = 0;
    while (edge_cnt - tx_base < 16 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({output_clk_out, result_valid_out, abort_out, busy_out} !== 4'b0 || result_out !== 32'h0 || frame_cnt_out !== 8'h0) begin
      errors++; $display("FAIL midreset: got ctrl %b result %h cnt %0d expected 0", {output_clk_out, result_valid_out, abort_out, busy_out}, result_out, frame_cnt_out);
    end
    output_rdy_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++;
    if (abort_cnt != a0) begin errors++; $display("FAIL midreset_abort: got %0d expected %0d", abort_cnt, a0); end
    run_frame(32'h12345678, ok);
    checks++;
    if (!ok || result_out !== 32'h12345678 || frame_cnt_out !== 8'd1) begin
      errors++; $display("FAIL midreset_next: got %h cnt %0d expected 12345678 1", result_out, frame_cnt_out);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad, a0;
    logic [31:0] w;
    a0 = abort_cnt;
    tx_word = 32'hA5A50F0F;
    tx_base = edge_cnt;
    @(negedge clk_in);
    output_rdy_in = 1'b1;
    repeat (1000) @(negedge clk_in);
    checks++;
    if (edge_cnt - tx_base != 32 || frame_cnt_out !== 8'd2 || result_out !== 32'hA5A50F0F) begin
      errors++; $display("FAIL hold_high: got edges %0d cnt %0d result %h expected 32 2 a5a50f0f", edge_cnt - tx_base, frame_cnt_out, result_out);
    end
    output_rdy_in = 1'b0;
    repeat (4) @(negedge clk_in);
    bad = 0;
    w = 32'h0;
    for (int i = 0; i < 256; i++) begin
      w = 32'h9E3779B9 * (i + 1);
      run_frame(w, ok);
      if (!ok || result_out !== w) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_frames: got %0d bad frames expected 0", bad); end
    checks++;
    if (!wrap_seen || frame_cnt_out !== 8'd2) begin
      errors++; $display("FAIL b2b_wrap: got wrap %0d cnt %0d expected 1 2", wrap_seen, frame_cnt_out);
    end
    checks++;
    if (abort_cnt != a0) begin errors++; $display("FAIL b2b_abort: got %0d expected %0d", abort_cnt, a0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Downstream consumer of the FP adder's serial result port.
- Detects output_rdy, generates the output_clk strobe train and samples serial_out MSB-first.
- Assembles the WIDTH-bit IEEE-754 result and presents it to on-chip logic through a valid/ready holding register.
- Sits between the adder and the wishbone/LA readback logic, all in the clk_in domain.

Parameters:
- WIDTH, 32: result word width in bits.
- HALF_PERIOD, 4: clk_in cycles per output_clk phase. Minimum 2; must exceed the adder's output_clk input synchroniser depth.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk_in  input  1  system clock; all logic is rising-edge.
- rst_in  input  1  asynchronous, active-low reset.
- output_rdy_in  input  1  adder result-available flag; treated as asynchronous.
- serial_in  input  1  adder serial_out; treated as asynchronous.
- output_clk_out  output  1  shift strobe to the adder's output_clk_in; the adder advances one bit per rising edge.
- result_out  output  WIDTH  last complete result.
- result_valid_out  output  1  result_out holds an unconsumed word.
- result_ready_in  input  1  consumer accepts result_out this cycle.
- abort_out  output  1  one-cycle pulse when a frame is abandoned.
- busy_out  output  1  high in LOW, HIGH and DONE states.
- frame_cnt_out  output  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset:
  - Assertion immediately forces all outputs and registers to 0 and the state to IDLE.
  - Mid-frame reset discards the partial word with no abort pulse.
  - Deassertion is synchronised through 2 flops.
- Input synchronisation: output_rdy_in and serial_in each pass through 2 flops (rdy_s, ser_s). All decisions use the synchronised values.
- States: IDLE, LOW, HIGH, DONE, WAIT_DROP.
- IDLE:
  - output_clk_out = 0.
  - Go to LOW when rdy_s = 1 and the holding register is free (result_valid_out = 0, or result_ready_in = 1 this cycle).
  - Entering LOW clears bit_cnt and phase_cnt.
- LOW:
  - output_clk_out = 0 for HALF_PERIOD cycles.
  - On the last cycle: shift ser_s into the LSB of the shift register (shift left), drive output_clk_out = 1, go to HIGH.
- HIGH:
  - output_clk_out = 1 for HALF_PERIOD cycles.
  - On the last cycle, drive output_clk_out = 0.
  - If bit_cnt = WIDTH-1, go to DONE; otherwise increment bit_cnt and go to LOW.
- DONE (one cycle):
  - result_out <= shift register; result_valid_out <= 1; frame_cnt_out increments (max wraps to 0).
  - Go to WAIT_DROP.
- WAIT_DROP: stay until rdy_s = 0, then go to IDLE. A result is never read twice.
- Abort:
  - In LOW or HIGH, rdy_s = 0 forces output_clk_out = 0 next cycle, abort_out = 1 for exactly one cycle, and the state to IDLE.
  - The partial word is discarded; result_out, result_valid_out and frame_cnt_out are unchanged.
- Holding register handshake:
  - result_valid_out clears on the cycle after result_valid_out and result_ready_in are both 1.
  - result_out holds its value until the next DONE.
  - If DONE and a consumption coincide, the new word wins and valid stays 1.
- Frame timing:
  - Edge 1 is the first clk_in edge sampling output_rdy_in = 1.
  - The state enters LOW at edge 3.
  - output_clk_out rises after edges 7, 15, …, and falls after edges 11, 19, ….
  - 32 rising edges in total (WIDTH=32, HALF_PERIOD=4).
  - result_valid_out = 1 after edge 260.
- Bit order: the first sampled bit becomes result_out[WIDTH-1] (MSB-first, sign bit first).

Test Plan:
1. Adder model serialises 0x40490FDB on output_rdy_in rising → exactly 32 output_clk_out rising edges, result_out = 0x40490FDB, result_valid_out high after edge 260, frame_cnt_out = 1, abort_out never high.
2. result_ready_in held 0 with result 0x3F800000 unconsumed; second frame 0xC0000000 pending → no output_clk_out activity until result_ready_in pulses; then the second frame runs and result_out = 0xC0000000.
3. output_rdy_in dropped after 10 output_clk_out rising edges → output_clk_out low within 3 cycles, single abort_out pulse, result_out and frame_cnt_out unchanged, returns to IDLE.
4. rst_in driven low at bit 16 of a frame → all outputs 0 in the same cycle with no clock edge needed, no abort_out; after release, a fresh frame 0x12345678 is captured correctly.
5. output_rdy_in held high for 1000 cycles after one frame → exactly one frame captured (WAIT_DROP). Then 256 frames back-to-back → frame_cnt_out wraps 255→0.
